pipe_ctrl: RTL and testbench

Pipeline stall/flush controller for the 5-stage integer core. Merges stall requests from ID, EX and MEM into one stall vector that holds the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Sequences multi-cycle EX operations (div, madd/msub) with an internal cycle counter. Redirects the pipeline on exceptions and ERET.

---
 rtl/cpu_defs.sv | 46 ++++
 rtl/pipe_ctrl_mc_timer.sv | 44 ++++
 rtl/pipe_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared pipeline-control definitions: stall encodings, controller states, constants.
// No logic of its own; consumed by pipe_ctrl and its sub-modules.
// Not applicable: no flow control here.
package cpu_defs;

    // Hold vectors, one bit per pipeline register, [0]=PC ... [5]=WB.
    // Each encoding is a superset of the ones below it, so numeric max equals
    // "deepest stall wins".
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Controller states.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MULTI = 2'd1,
        ST_FLUSH = 2'd2
    } pc_state_e;

    // Redirect request, as presented to the front end.
    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
    } redir_t;

    // Pick the deeper of two stall vectors.
    function automatic logic [5:0] stall_max(input logic [5:0] a, input logic [5:0] b);
        return (a > b) ? a : b;
    endfunction

    // Merge the per-stage stall requests into one hold vector.
    function automatic logic [5:0] stall_merge(input logic req_id,
                                               input logic req_ex,
                                               input logic req_mem);
        logic [5:0] s;
        s = STALL_NONE;
        if (req_id)  s = stall_max(s, STALL_ID);
        if (req_ex)  s = stall_max(s, STALL_EX);
        if (req_mem) s = stall_max(s, STALL_MEM);
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_mc_timer.sv
// Load/decrement cycle counter for multi-cycle EX operations, with last-cycle flag.
// Registered count; last is combinational from the current count.
// No backpressure: decrement is unconditional when requested, clear beats load.
module pipe_ctrl_mc_timer
    import cpu_defs::*;
#(
    parameter int MC_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            load,
    input  logic [MC_W-1:0] load_val,
    input  logic            dec,
    output logic            last
);

    logic [MC_W-1:0] cnt_q;
    logic [MC_W-1:0] cnt_d;

    // Next count: clear (abort) wins over load, load wins over decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - MC_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == MC_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges stage stall requests, sequences multi-cycle EX ops, redirects on exception/ERET.
// Outputs are combinational from inputs and current state (zero latency); state, timer and perf counter are registered.
// Stall vector holds upstream registers; a redirect overrides every stall and is followed by one quiet FLUSH cycle.
module pipe_ctrl
    import cpu_defs::*;
#(
    parameter int MC_W   = 6,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              ex_mc_start,
    input  logic [MC_W-1:0]   ex_mc_cycles,
    input  logic              excp_valid,
    input  logic [31:0]       excp_vector,
    input  logic              eret,
    input  logic [31:0]       epc,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              mc_done,
    output logic              mc_abort,
    output logic [PERF_W-1:0] stall_cnt
);

    pc_state_e         state_q;
    pc_state_e         state_d;
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] stall_cnt_d;

    redir_t            redir;
    logic [5:0]        req_stall;
    logic              mc_short;
    logic              tmr_clear;
    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_last;

    // Redirect request. A FLUSH cycle ignores excp/eret because the MEM-stage
    // instruction that raised them is still visible there for one more cycle.
    always_comb begin
        redir.vld = (excp_valid || eret) && (state_q != ST_FLUSH);
        redir.pc  = excp_valid ? excp_vector : epc;
    end

    // Stage stall requests merged once, reused by every state.
    assign req_stall = stall_merge(stallreq_id, stallreq_ex, stallreq_mem);

    // A length of 0 or 1 completes in the accepting cycle without entering MULTI.
    assign mc_short = (ex_mc_cycles <= MC_W'(1));

    // Main control: outputs, next state and timer controls.
    always_comb begin
        state_d   = state_q;
        stall     = STALL_NONE;
        flush     = 1'b0;
        new_pc    = ZERO_WORD;
        mc_done   = 1'b0;
        mc_abort  = 1'b0;
        tmr_clear = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;

        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (redir.vld) begin
                        flush   = 1'b1;
                        new_pc  = redir.pc;
                        state_d = ST_FLUSH;
                        // An op accepted this same cycle dies with the redirect.
                        if (ex_mc_start) begin
                            mc_abort  = 1'b1;
                            tmr_clear = 1'b1;
                        end
                    end else begin
                        stall = req_stall;
                        if (ex_mc_start) begin
                            stall = stall_max(stall, STALL_EX);
                            if (mc_short) begin
                                mc_done = 1'b1;
                            end else begin
                                // Accepting cycle is cycle 1, so N-1 remain.
                                tmr_load = 1'b1;
                                state_d  = ST_MULTI;
                            end
                        end
                    end
                end

                ST_MULTI: begin
                    if (redir.vld) begin
                        flush     = 1'b1;
                        new_pc    = redir.pc;
                        mc_abort  = 1'b1;
                        tmr_clear = 1'b1;
                        state_d   = ST_FLUSH;
                    end else begin
                        // The op keeps counting even while MEM holds the pipe.
                        stall   = stall_max(req_stall, STALL_EX);
                        tmr_dec = 1'b1;
                        if (tmr_last) begin
                            mc_done = 1'b1;
                            state_d = ST_RUN;
                        end
                    end
                end

                ST_FLUSH: begin
                    state_d = ST_RUN;
                end

                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Performance counter: cycles with the PC held, wrapping naturally.
    always_comb begin
        stall_cnt_d = stall_cnt_q + PERF_W'(stall[0]);
    end

    // State and perf counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

    pipe_ctrl_mc_timer #(
        .MC_W (MC_W)
    ) u_mc_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (ex_mc_cycles - MC_W'(1)),
        .dec      (tmr_dec),
        .last     (tmr_last)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle vector table plus a hand-written abort corner.
// Inputs driven 1 ns after posedge, outputs sampled on negedge.
// Perf counter instantiated narrow so wrap-around is reachable in a short run.
module tb_pipe_ctrl;

    localparam int MC_W   = 6;
    localparam int PERF_W = 4;

    logic              clk;
    logic              rst;
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              stallreq_mem;
    logic              ex_mc_start;
    logic [MC_W-1:0]   ex_mc_cycles;
    logic              excp_valid;
    logic [31:0]       excp_vector;
    logic              eret;
    logic [31:0]       epc;
    logic [5:0]        stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic              mc_done;
    logic              mc_abort;
    logic [PERF_W-1:0] stall_cnt;

    pipe_ctrl #(
        .MC_W   (MC_W),
        .PERF_W (PERF_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .excp_valid   (excp_valid),
        .excp_vector  (excp_vector),
        .eret         (eret),
        .epc          (epc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_done      (mc_done),
        .mc_abort     (mc_abort),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        flags;   // {rst, stallreq_id, stallreq_ex, stallreq_mem}
        logic              mcs;
        logic [MC_W-1:0]   n;
        logic              ev;
        logic              er;
        logic [31:0]       vec;
        logic [31:0]       ep;
        logic [5:0]        e_stall;
        logic              e_flush;
        logic [31:0]       e_pc;
        logic              e_done;
        logic              e_abort;
        logic [PERF_W-1:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic [3:0] flags, input logic mcs, input logic [MC_W-1:0] n,
                                input logic ev, input logic er, input logic [31:0] vec,
                                input logic [31:0] ep, input logic [5:0] es, input logic ef,
                                input logic [31:0] epx, input logic ed, input logic ea,
                                input logic [PERF_W-1:0] ec);
        vec_t v;
        v.flags = flags; v.mcs = mcs; v.n = n; v.ev = ev; v.er = er; v.vec = vec; v.ep = ep;
        v.e_stall = es; v.e_flush = ef; v.e_pc = epx; v.e_done = ed; v.e_abort = ea; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        {rst, stallreq_id, stallreq_ex, stallreq_mem} = v.flags;
        ex_mc_start  = v.mcs;
        ex_mc_cycles = v.n;
        excp_valid   = v.ev;
        eret         = v.er;
        excp_vector  = v.vec;
        epc          = v.ep;
        @(negedge clk);
        chk("stall",     idx, 32'(stall),     32'(v.e_stall));
        chk("flush",     idx, 32'(flush),     32'(v.e_flush));
        chk("new_pc",    idx, new_pc,         v.e_pc);
        chk("mc_done",   idx, 32'(mc_done),   32'(v.e_done));
        chk("mc_abort",  idx, 32'(mc_abort),  32'(v.e_abort));
        chk("stall_cnt", idx, 32'(stall_cnt), 32'(v.e_cnt));
    endtask

    initial begin
        rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
        ex_mc_start = 1'b0; ex_mc_cycles = '0; excp_valid = 1'b0; eret = 1'b0;
        excp_vector = '0; epc = '0;
        repeat (2) @(posedge clk);

        //              flags  mcs   n      ev    er    vec       epc        stall     fl    pc        done  abrt  cnt
        tbl.push_back(mk(4'b1001, 1'b1, 6'd3, 1'b1, 1'b0, 32'h20,   32'h0,     6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd0));  // 0 reset forces zero
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd0));  // 1 idle
        tbl.push_back(mk(4'b0100, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h07, 1'b0, 32'h0,    1'b0, 1'b0, 4'd0));  // 2 ID stall
        tbl.push_back(mk(4'b0011, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h1F, 1'b0, 32'h0,    1'b0, 1'b0, 4'd1));  // 3 EX+MEM, MEM wins
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd2));  // 4 stall_cnt=2
        tbl.push_back(mk(4'b0010, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h0F, 1'b0, 32'h0,    1'b0, 1'b0, 4'd2));  // 5 EX stall
        tbl.push_back(mk(4'b0000, 1'b1, 6'd3, 1'b0, 1'b0, 32'h0,    32'h0,     6'h0F, 1'b0, 32'h0,    1'b0, 1'b0, 4'd3));  // 6 N=3 at T
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h0F, 1'b0, 32'h0,    1'b0, 1'b0, 4'd4));  // 7 T+1
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h0F, 1'b0, 32'h0,    1'b1, 1'b0, 4'd5));  // 8 T+2 done
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd6));  // 9 T+3 free
        tbl.push_back(mk(4'b0000, 1'b1, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h0F, 1'b0, 32'h0,    1'b1, 1'b0, 4'd6));  // 10 N=0
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd7));  // 11 still RUN
        tbl.push_back(mk(4'b0000, 1'b1, 6'd1, 1'b0, 1'b0, 32'h0,    32'h0,     6'h0F, 1'b0, 32'h0,    1'b1, 1'b0, 4'd7));  // 12 N=1
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd8));  // 13 still RUN
        tbl.push_back(mk(4'b0000, 1'b1, 6'd5, 1'b0, 1'b0, 32'h0,    32'h0,     6'h0F, 1'b0, 32'h0,    1'b0, 1'b0, 4'd8));  // 14 N=5 start
        tbl.push_back(mk(4'b0001, 1'b1, 6'd2, 1'b0, 1'b0, 32'h0,    32'h0,     6'h1F, 1'b0, 32'h0,    1'b0, 1'b0, 4'd9));  // 15 MEM in MULTI, start ignored
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b1, 1'b0, 32'h20,   32'h0,     6'h00, 1'b1, 32'h20,   1'b0, 1'b1, 4'd10)); // 16 excp aborts
        tbl.push_back(mk(4'b0100, 1'b1, 6'd3, 1'b1, 1'b1, 32'h20,   32'h1000,  6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd10)); // 17 FLUSH ignores all
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd10)); // 18 back to RUN
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b1, 1'b1, 32'h20,   32'h1000,  6'h00, 1'b1, 32'h20,   1'b0, 1'b0, 4'd10)); // 19 excp beats eret
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd10)); // 20 FLUSH
        tbl.push_back(mk(4'b0001, 1'b0, 6'd0, 1'b0, 1'b1, 32'h0,    32'h1000,  6'h00, 1'b1, 32'h1000, 1'b0, 1'b0, 4'd10)); // 21 eret over MEM stall
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd10)); // 22 FLUSH
        tbl.push_back(mk(4'b0000, 1'b1, 6'd3, 1'b1, 1'b0, 32'h40,   32'h0,     6'h00, 1'b1, 32'h40,   1'b0, 1'b1, 4'd10)); // 23 start+excp same cycle
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd10)); // 24 FLUSH
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd10)); // 25 no MULTI left
        tbl.push_back(mk(4'b0000, 1'b1, 6'd4, 1'b0, 1'b0, 32'h0,    32'h0,     6'h0F, 1'b0, 32'h0,    1'b0, 1'b0, 4'd10)); // 26 N=4
        tbl.push_back(mk(4'b0001, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h1F, 1'b0, 32'h0,    1'b0, 1'b0, 4'd11)); // 27 MEM, still counts
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h0F, 1'b0, 32'h0,    1'b0, 1'b0, 4'd12)); // 28
        tbl.push_back(mk(4'b0100, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h0F, 1'b0, 32'h0,    1'b1, 1'b0, 4'd13)); // 29 done, ID merged
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd14)); // 30
        tbl.push_back(mk(4'b0000, 1'b1, 6'd6, 1'b0, 1'b0, 32'h0,    32'h0,     6'h0F, 1'b0, 32'h0,    1'b0, 1'b0, 4'd14)); // 31 N=6
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h0F, 1'b0, 32'h0,    1'b0, 1'b0, 4'd15)); // 32
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h0F, 1'b0, 32'h0,    1'b0, 1'b0, 4'd0));  // 33 perf counter wraps
        tbl.push_back(mk(4'b1001, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd1));  // 34 rst mid-MULTI
        tbl.push_back(mk(4'b0001, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h1F, 1'b0, 32'h0,    1'b0, 1'b0, 4'd0));  // 35 inputs only, cnt cleared
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd1));  // 36 op abandoned
        tbl.push_back(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0,    32'h0,     6'h00, 1'b0, 32'h0,    1'b0, 1'b0, 4'd1));  // 37 no late mc_done

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Redirect landing on the final cycle of an op: abort wins, no done.
        apply(mk(4'b0000, 1'b1, 6'd2, 1'b0, 1'b0, 32'h0, 32'h0,  6'h0F, 1'b0, 32'h0,  1'b0, 1'b0, 4'd1), 100);
        apply(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b1, 32'h0, 32'h80, 6'h00, 1'b1, 32'h80, 1'b0, 1'b1, 4'd2), 101);
        apply(mk(4'b0000, 1'b1, 6'd2, 1'b0, 1'b0, 32'h0, 32'h0,  6'h00, 1'b0, 32'h0,  1'b0, 1'b0, 4'd2), 102);
        apply(mk(4'b0000, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 32'h0,  6'h00, 1'b0, 32'h0,  1'b0, 1'b0, 4'd2), 103);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
